// File: rtl/stack_mem_ctrl_pkg.sv
// Shared encodings for the memory-stage stack controller.
// Covers the push/pop request field, the CALL/RET cycle markers and the sequencing FSM states.
package stack_mem_ctrl_pkg;

    localparam logic [1:0] PP_NONE   = 2'b00;
    localparam logic [1:0] PP_PUSH   = 2'b01;
    localparam logic [1:0] PP_RSVD   = 2'b10;
    localparam logic [1:0] PP_POP    = 2'b11;

    localparam logic [1:0] FT_NONE   = 2'b00;
    localparam logic [1:0] FT_SECOND = 2'b01;
    localparam logic [1:0] FT_FIRST  = 2'b11;

    typedef enum logic [1:0] {
        SM_IDLE    = 2'd0,
        SM_CALL_HI = 2'd1,
        SM_RET_LO  = 2'd2
    } sm_state_t;

endpackage

// File: rtl/stack_pointer.sv
// Descending stack pointer with full/empty detection and sticky overflow/underflow flags.
// The pointer is post-decremented on push and pre-incremented on pop; address 0 is never used.
module stack_pointer #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_req,
    input  logic              pop_req,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] sp_plus1,
    output logic              push_ok,
    output logic              pop_ok,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W-1:0] TOP = '1;

    logic [ADDR_W-1:0] sp_reg;
    logic              overflow_reg;
    logic              underflow_reg;
    logic              full;
    logic              empty;

    assign full     = (sp_reg == '0);
    assign empty    = (sp_reg == TOP);
    assign push_ok  = push_req && !full;
    assign pop_ok   = pop_req && !empty;
    assign sp       = sp_reg;
    assign sp_plus1 = sp_reg + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_reg        <= TOP;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                sp_reg <= sp_reg - 1'b1;
            end else if (pop_ok) begin
                sp_reg <= sp_plus1;
            end
            if (push_req && full) begin
                overflow_reg <= 1'b1;
            end
            if (pop_req && empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: rtl/stack_mem_ctrl.sv
// Memory-stage controller: stack push/pop, LDD/STD muxing onto the data-memory port,
// and the two-cycle CALL/RET sequencing that saves and reassembles the 32-bit PC.
module stack_mem_ctrl
    import stack_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        enablePushOrPop,
    input  logic [1:0]        firstTimeCall,
    input  logic [1:0]        firstTimeRET,
    input  logic              MR,
    input  logic              MW,
    input  logic [15:0]       aluOut,
    input  logic [15:0]       storeData,
    input  logic [31:0]       pcNext,
    input  logic [15:0]       memRdata,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memWe,
    output logic [15:0]       memWdata,
    output logic [15:0]       rdData,
    output logic [ADDR_W-1:0] sp,
    output logic [31:0]       retPc,
    output logic              retPcValid,
    output logic              stackOverflow,
    output logic              stackUnderflow,
    output logic              protocolErr
);

    sm_state_t         state_reg;
    sm_state_t         state_next;
    logic [15:0]       hi_hold_reg;
    logic [15:0]       hi_hold_next;
    logic [31:0]       ret_pc_reg;
    logic              ret_pc_valid_reg;
    logic              protocol_err_reg;

    logic              is_push;
    logic              is_pop;
    logic              is_rsvd;
    logic              call_second;
    logic              ret_second;
    logic              eff_idle;
    logic              call_first;
    logic              ret_first;
    logic              seq_break;
    logic              ret_load;
    logic              perr_set;

    logic [ADDR_W-1:0] sp_cur;
    logic [ADDR_W-1:0] sp_plus1;
    logic              push_ok;
    logic              pop_ok;

    stack_pointer #(
        .ADDR_W (ADDR_W)
    ) u_stack_pointer (
        .clk       (clk),
        .rst       (rst),
        .push_req  (is_push),
        .pop_req   (is_pop),
        .sp        (sp_cur),
        .sp_plus1  (sp_plus1),
        .push_ok   (push_ok),
        .pop_ok    (pop_ok),
        .overflow  (stackOverflow),
        .underflow (stackUnderflow)
    );

    assign is_push = (enablePushOrPop == PP_PUSH);
    assign is_pop  = (enablePushOrPop == PP_POP);
    assign is_rsvd = (enablePushOrPop == PP_RSVD);

    // A second-half state that does not see its expected cycle falls back to IDLE
    // and the current inputs are handled exactly as in IDLE.
    assign call_second = (state_reg == SM_CALL_HI) && (firstTimeCall == FT_SECOND) && is_push;
    assign ret_second  = (state_reg == SM_RET_LO) && (firstTimeRET == FT_SECOND) && is_pop;
    assign eff_idle    = !call_second && !ret_second;
    assign seq_break   = (state_reg != SM_IDLE) && eff_idle;
    assign call_first  = eff_idle && (firstTimeCall == FT_FIRST) && is_push;
    assign ret_first   = eff_idle && (firstTimeRET == FT_FIRST) && is_pop;

    always_comb begin
        memAddr      = aluOut[ADDR_W-1:0];
        memWe        = 1'b0;
        memWdata     = storeData;
        rdData       = 16'h0000;
        state_next   = SM_IDLE;
        hi_hold_next = hi_hold_reg;
        ret_load     = 1'b0;
        perr_set     = is_rsvd || seq_break;

        if (is_push) begin
            memAddr = sp_cur;
            memWe   = push_ok;
            if (call_second) begin
                memWdata = hi_hold_reg;
            end else if (call_first) begin
                memWdata     = pcNext[15:0];
                hi_hold_next = pcNext[31:16];
                state_next   = SM_CALL_HI;
            end else begin
                memWdata = aluOut;
            end
        end else if (is_pop) begin
            memAddr = sp_plus1;
            if (pop_ok) begin
                rdData = memRdata;
            end
            if (ret_first) begin
                hi_hold_next = memRdata;
                state_next   = SM_RET_LO;
            end
            // A suppressed second pop must not present a bogus return address.
            if (ret_second && pop_ok) begin
                ret_load = 1'b1;
            end
        end else if (MW) begin
            memWe = 1'b1;
        end else if (MR) begin
            rdData = memRdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= SM_IDLE;
            hi_hold_reg      <= 16'h0000;
            ret_pc_reg       <= 32'h0000_0000;
            ret_pc_valid_reg <= 1'b0;
            protocol_err_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            hi_hold_reg      <= hi_hold_next;
            ret_pc_valid_reg <= ret_load;
            if (ret_load) begin
                ret_pc_reg <= {hi_hold_reg, memRdata};
            end
            if (perr_set) begin
                protocol_err_reg <= 1'b1;
            end
        end
    end

    assign sp          = sp_cur;
    assign retPc       = ret_pc_reg;
    assign retPcValid  = ret_pc_valid_reg;
    assign protocolErr = protocol_err_reg;

endmodule

// File: doc/stack_mem_ctrl.md
# stack_mem_ctrl

Memory-stage stack and data-memory access controller: the consumer of the decode-stage `enablePushOrPop`, `firstTimeCall`, `firstTimeRET`, `MR` and `MW` signals after they travel down the pipeline. It owns the stack pointer and sequences the two-cycle CALL (push PC low, then high) and RET (pop PC high, then low) protocols. It drives the single-port data memory address, write enable and write data, and returns load and pop data for write-back. For RET it reassembles the 32-bit return PC for the fetch stage.

## Interface
- `ADDR_W`, 11: data-memory word-address width; stack top `TOP = 2^ADDR_W-1`.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enablePushOrPop` in 2: 00 none, 01 push, 11 pop, 10 reserved.
- `firstTimeCall` in 2: 11 first CALL cycle, 01 second CALL cycle, 00 none.
- `firstTimeRET` in 2: 11 first RET cycle, 01 second RET cycle, 00 none.
- `MR`, `MW` in 1: memory read (LDD/POP) and memory write (STD/PUSH).
- `aluOut` in 16: LDD/STD address (low `ADDR_W` bits); PUSH data.
- `storeData` in 16: STD write data.
- `pcNext` in 32: PC+1 carried with the instruction.
- `memRdata` in 16: data-memory read data, combinational read.
- `memAddr` out ADDR_W, `memWe` out 1, `memWdata` out 16: memory port.
- `rdData` out 16: data for write-back.
- `sp` out ADDR_W: current stack pointer.
- `retPc` out 32, `retPcValid` out 1: reassembled return PC.
- `stackOverflow`, `stackUnderflow`, `protocolErr` out 1: sticky error flags.

## Operation
- Push uses post-decrement: write to `mem[sp]`, then `sp <= sp-1`. Pop uses pre-increment: read `mem[sp+1]`, then `sp <= sp+1`. Address 0 is never used by the stack, so capacity is `TOP` words.
- Access priority per cycle:
  - Push/pop (`enablePushOrPop` ≠ 00) takes precedence.
  - Otherwise `MW` performs STD: `memAddr = aluOut[ADDR_W-1:0]`, `memWdata = storeData`, `memWe = 1`.
  - Otherwise `MR` performs LDD: same address, `rdData = memRdata`.
  - Otherwise: `memWe = 0`, `rdData = 0`.
- Plain PUSH (`firstTimeCall` = 00) writes `aluOut`. Plain POP sets `rdData = memRdata`.
- Overflow: a push with `sp == 0` is suppressed (`memWe = 0`, sp unchanged) and sets `stackOverflow`. Underflow: a pop with `sp == TOP` is suppressed (`rdData = 0`, sp unchanged) and sets `stackUnderflow`.
- `enablePushOrPop = 10` is treated as 00 and sets `protocolErr`.
- FSM states: IDLE, CALL_HI, RET_LO.
  - IDLE + `firstTimeCall` = 11 with push: push `pcNext[15:0]`, latch `pcNext[31:16]` into `hiHold`, go to CALL_HI.
  - CALL_HI + `firstTimeCall` = 01 with push: push `hiHold` (current `pcNext` ignored), go to IDLE.
  - IDLE + `firstTimeRET` = 11 with pop: pop, latch `memRdata` into `hiHold`, go to RET_LO.
  - RET_LO + `firstTimeRET` = 01 with pop: pop, register `retPc = {hiHold, memRdata}`, pulse `retPcValid`, go to IDLE.
  - CALL_HI or RET_LO receiving anything other than its expected second cycle: set `protocolErr`, go to IDLE, and process the current inputs as an IDLE-state cycle.
- A suppressed first push or pop still advances the FSM. A suppressed second RET pop does not assert `retPcValid`.
- Error flags clear only on reset.

## Timing
- `memAddr`, `memWe`, `memWdata` and `rdData` are combinational from the inputs and registered state, within the same cycle.
- `sp`, the FSM state and `hiHold` update at the clock edge ending the access.
- `retPcValid` is high for exactly the one cycle after the second RET cycle. `retPc` holds its value until the next RET completes.
- Reset values: `sp = TOP`, FSM IDLE, `hiHold = 0`, `retPc = 0`, `retPcValid = 0`, all flags 0.
- Asserting `rst` mid-CALL or mid-RET aborts the sequence immediately. No `retPcValid` is produced.

## Structure
- In `defines.v`:
  - `PP_NONE`/`PP_PUSH`/`PP_POP` = 00/01/11.
  - `FT_FIRST`/`FT_SECOND` = 11/01.
  - FSM state encodings `SM_IDLE`/`SM_CALL_HI`/`SM_RET_LO`.
- One sub-module, `stack_pointer`: holds the SP register, its increment/decrement, and the full/empty detection driving the overflow/underflow flags. Its outputs are `sp` and `spPlus1`.
- FSM, memory muxing and RET reassembly stay in `stack_mem_ctrl`.

## Test plan
- **Push/pop:** after reset, push `aluOut = 0x1234` → `memAddr = 0x7FF`, `memWe = 1`, `memWdata = 0x1234`, next `sp = 0x7FE`. Then pop → `memAddr = 0x7FF`, `rdData = memRdata`, `sp = 0x7FF`.
- **CALL:** `pcNext = 0x00010042` with FT_FIRST, then FT_SECOND with `pcNext = 0xDEADBEEF` → writes 0x0042 @0x7FF and 0x0001 @0x7FE; `sp = 0x7FD`.
- **RET:** following the CALL scenario, RET reads @0x7FE then @0x7FF → one cycle later `retPcValid = 1`, `retPc = 0x00010042`, `sp = 0x7FF`.
- **Bounds (`ADDR_W = 3`):** 7 pushes succeed; the 8th has `memWe = 0`, `stackOverflow = 1`, `sp = 0`. A pop at reset gives `stackUnderflow = 1`, `sp = 7`.
- **Broken CALL and STD:** FT_FIRST CALL followed by a plain ADD cycle → `protocolErr = 1`, FSM IDLE, `sp = 0x7FE`. STD with `aluOut = 0x0123`, `storeData = 0xBEEF` → `memAddr = 0x123`, `memWe = 1`, `memWdata = 0xBEEF`.
- **Reset mid-RET:** assert `rst` after the first RET cycle → `sp = 0x7FF`, FSM IDLE, `retPcValid` never asserts.
